// File: rtl/vga_rect_fill.sv
// Rectangle-fill sequencer for the 160x120 pixel-plot port: walks the clipped
// rectangle row-major, one pixel per clock, with a hold stall and done pulse.
module vga_rect_fill #(
   parameter int unsigned XRES = 160,
   parameter int unsigned YRES = 120,
   parameter int unsigned XW   = 8,
   parameter int unsigned YW   = 7,
   parameter int unsigned CW   = 3
) (
   input  logic          CLOCK_50,
   input  logic          Resetn,
   input  logic          start,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   input  logic [XW:0]   w,
   input  logic [YW:0]   h,
   input  logic [CW-1:0] color,
   input  logic          hold,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [XW-1:0] VGA_X,
   output logic [YW-1:0] VGA_Y,
   output logic [CW-1:0] VGA_COLOR,
   output logic          plot
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;

   localparam logic [XW+1:0] XLIM  = (XW+2)'(XRES);
   localparam logic [YW+1:0] YLIM  = (YW+2)'(YRES);
   localparam logic [XW+1:0] XONE  = (XW+2)'(1);
   localparam logic [YW+1:0] YONE  = (YW+2)'(1);
   localparam logic [XW-1:0] XSTEP = XW'(1);
   localparam logic [YW-1:0] YSTEP = YW'(1);

   state_t        state_q;
   logic [XW-1:0] x0_q, cx_q, vx_q;
   logic [YW-1:0] y0_q, cy_q, vy_q;
   logic [XW:0]   w_q;
   logic [YW:0]   h_q;
   logic [CW-1:0] col_q, vc_q;
   logic [XW+1:0] xe_q;
   logic [YW+1:0] ye_q;
   logic          ready_q, busy_q, done_q, plot_q;

   logic [XW+1:0] xsum_d, xe_d;
   logic [YW+1:0] ysum_d, ye_d;
   logic          empty_d, last_col_d, last_row_d;

   // Sums are two bits wider than the coordinate so x0+w never wraps.
   always_comb begin
      xsum_d     = {2'b00, x0_q} + {1'b0, w_q};
      ysum_d     = {2'b00, y0_q} + {1'b0, h_q};
      xe_d       = (xsum_d > XLIM) ? XLIM : xsum_d;
      ye_d       = (ysum_d > YLIM) ? YLIM : ysum_d;
      empty_d    = (w_q == '0) || (h_q == '0) ||
                   ({2'b00, x0_q} >= XLIM) || ({2'b00, y0_q} >= YLIM);
      last_col_d = (({2'b00, cx_q} + XONE) == xe_q);
      last_row_d = (({2'b00, cy_q} + YONE) == ye_q);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         plot_q  <= 1'b0;
         vx_q    <= '0;
         vy_q    <= '0;
         vc_q    <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               // The first IDLE cycle after DONE still shows ready=0, so a
               // start there is not accepted.
               if (ready_q && start) begin
                  x0_q    <= x0;
                  y0_q    <= y0;
                  w_q     <= w;
                  h_q     <= h;
                  col_q   <= color;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_LOAD: begin
               xe_q    <= xe_d;
               ye_q    <= ye_d;
               cx_q    <= x0_q;
               cy_q    <= y0_q;
               state_q <= empty_d ? S_DONE : S_FILL;
            end
            S_FILL: begin
               if (hold) begin
                  plot_q <= 1'b0;
               end else begin
                  plot_q <= 1'b1;
                  vx_q   <= cx_q;
                  vy_q   <= cy_q;
                  vc_q   <= col_q;
                  if (last_col_d) begin
                     cx_q <= x0_q;
                     if (last_row_d) begin
                        state_q <= S_DONE;
                     end else begin
                        cy_q <= cy_q + YSTEP;
                     end
                  end else begin
                     cx_q <= cx_q + XSTEP;
                  end
               end
            end
            S_DONE: begin
               plot_q  <= 1'b0;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready     = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign plot      = plot_q;
   assign VGA_X     = vx_q;
   assign VGA_Y     = vy_q;
   assign VGA_COLOR = vc_q;

endmodule
